// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the Maxnet winner-take-all controller.
// Words are IEEE-754 single precision; a word is zero when its magnitude bits are all clear.
package maxnet_pkg;

    localparam int DW    = 32;
    localparam int NODES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        ADD   = 3'd3,
        RELU  = 3'd4,
        CHECK = 3'd5,
        FEED  = 3'd6,
        DONE  = 3'd7
    } state_t;

    // Sign is ignored so that -0.0 counts as zero.
    function automatic logic is_zero(input logic [DW-1:0] word);
        return (word[30:0] == 31'd0);
    endfunction

endpackage

// File: rtl/maxnet_zero_detect.sv
// Counts the nonzero activation words and reports the lowest-indexed nonzero node.
// Purely combinational; the controller samples the result in its CHECK state.
module maxnet_zero_detect #(
    parameter int DW    = maxnet_pkg::DW,
    parameter int NODES = maxnet_pkg::NODES
) (
    input  logic [NODES*DW-1:0]        words,
    output logic [$clog2(NODES+1)-1:0] count,
    output logic [$clog2(NODES)-1:0]   first_idx
);
    import maxnet_pkg::*;

    localparam int CW = $clog2(NODES + 1);
    localparam int IW = $clog2(NODES);

    logic [NODES-1:0] nonzero;

    generate
        for (genvar gi = 0; gi < NODES; gi++) begin : g_nz
            assign nonzero[gi] = !is_zero(words[gi*DW +: DW]);
        end
    endgenerate

    // Scanning downwards leaves the lowest nonzero index in first_idx.
    always_comb begin
        count     = '0;
        first_idx = '0;
        for (int i = NODES - 1; i >= 0; i--) begin
            count = count + CW'(nonzero[i]);
            if (nonzero[i]) begin
                first_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/maxnet_ctrl.sv
// Sequencer for NODES parallel Maxnet PLU datapaths: loads activations, steps the
// multiply/add/ReLU stages and iterates until one node survives, none do, or the limit hits.
module maxnet_ctrl #(
    parameter int DW       = 32,
    parameter int NODES    = 4,
    parameter int MAX_ITER = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NODES*DW-1:0]           x_in,
    input  logic [NODES*DW-1:0]           plu_out,
    output logic [NODES*DW-1:0]           act_out,
    output logic                          w_we,
    output logic                          a_we,
    output logic                          r1_we,
    output logic                          r2_we,
    output logic                          r3_we,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NODES)-1:0]      winner,
    output logic                          no_winner,
    output logic                          timeout,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);
    import maxnet_pkg::*;

    localparam int CW = $clog2(NODES + 1);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int XW = $clog2(NODES);

    state_t              state_reg;
    logic [NODES*DW-1:0] act_reg;
    logic [CW-1:0]       nz_count;
    logic [XW-1:0]       nz_first;
    logic [IW-1:0]       iter_next;

    maxnet_zero_detect #(
        .DW    (DW),
        .NODES (NODES)
    ) u_zero_detect (
        .words     (plu_out),
        .count     (nz_count),
        .first_idx (nz_first)
    );

    assign act_out   = act_reg;
    assign iter_next = iter_count + IW'(1);

    // Outputs are registered with the state: each branch sets the strobes that
    // belong to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            act_reg    <= '0;
            w_we       <= 1'b0;
            a_we       <= 1'b0;
            r1_we      <= 1'b0;
            r2_we      <= 1'b0;
            r3_we      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= '0;
            no_winner  <= 1'b0;
            timeout    <= 1'b0;
            iter_count <= '0;
        end else begin
            w_we  <= 1'b0;
            a_we  <= 1'b0;
            r1_we <= 1'b0;
            r2_we <= 1'b0;
            r3_we <= 1'b0;
            done  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        act_reg    <= x_in;
                        winner     <= '0;
                        no_winner  <= 1'b0;
                        timeout    <= 1'b0;
                        iter_count <= '0;
                        w_we       <= 1'b1;
                        a_we       <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= LOAD;
                    end
                end
                LOAD, FEED: begin
                    r1_we     <= 1'b1;
                    state_reg <= MUL;
                end
                MUL: begin
                    r2_we     <= 1'b1;
                    state_reg <= ADD;
                end
                ADD: begin
                    r3_we     <= 1'b1;
                    state_reg <= RELU;
                end
                RELU: begin
                    state_reg <= CHECK;
                end
                CHECK: begin
                    act_reg    <= plu_out;
                    iter_count <= iter_next;
                    if (nz_count == CW'(1)) begin
                        winner    <= nz_first;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else if (nz_count == CW'(0)) begin
                        no_winner <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else if (iter_next == IW'(MAX_ITER)) begin
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        // Weights stay resident; only the new activations are reloaded.
                        a_we      <= 1'b1;
                        state_reg <= FEED;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Bench for maxnet_ctrl: four behavioural PLU datapaths (or a constant stub) close the loop;
// expected outcomes are queued at start and compared when done pulses.
`timescale 1ns/1ps
module tb_maxnet_ctrl;

    localparam int DW       = 32;
    localparam int NODES    = 4;
    localparam int MAX_ITER = 15;
    localparam int IW       = $clog2(MAX_ITER + 1);
    localparam int VW       = NODES * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [VW-1:0] x_in = '0;
    logic [VW-1:0] plu_out;
    logic [VW-1:0] act_out;
    logic          w_we, a_we, r1_we, r2_we, r3_we;
    logic          busy, done;
    logic [1:0]    winner;
    logic          no_winner, timeout;
    logic [IW-1:0] iter_count;

    always #5 clk = ~clk;

    maxnet_ctrl #(
        .DW       (DW),
        .NODES    (NODES),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x_in       (x_in),
        .plu_out    (plu_out),
        .act_out    (act_out),
        .w_we       (w_we),
        .a_we       (a_we),
        .r1_we      (r1_we),
        .r2_we      (r2_we),
        .r3_we      (r3_we),
        .busy       (busy),
        .done       (done),
        .winner     (winner),
        .no_winner  (no_winner),
        .timeout    (timeout),
        .iter_count (iter_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Single <-> double conversion for normal numbers; results truncate toward zero.
    function automatic real sp_to_real(input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = 11'(b[30:23]) + 11'd896;
        d = {b[31], e, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e <= 0) return 32'd0;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural PLU datapaths: node i computes relu(sum_j w[i][j]*a[j]).
    logic          stub_mode = 1'b0;
    logic [VW-1:0] stub_val  = '0;
    logic [VW-1:0] r3_bits   = '0;
    real           w_m  [NODES][NODES];
    real           a_m  [NODES];
    real           prod [NODES][NODES];
    real           sum_m[NODES];

    function automatic real row_sum(input int i);
        real s;
        s = 0.0;
        for (int j = 0; j < NODES; j++) s = s + prod[i][j];
        return s;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NODES; i++) begin
            if (w_we) for (int j = 0; j < NODES; j++) w_m[i][j] <= (i == j) ? 1.0 : -0.2;
            if (a_we) a_m[i] <= sp_to_real(act_out[i*DW +: DW]);
            if (r1_we) for (int j = 0; j < NODES; j++) prod[i][j] <= w_m[i][j] * a_m[j];
            if (r2_we) sum_m[i] <= row_sum(i);
            if (r3_we) r3_bits[i*DW +: DW] <= real_to_sp((sum_m[i] > 0.0) ? sum_m[i] : 0.0);
        end
    end

    assign plu_out = stub_mode ? stub_val : r3_bits;

    typedef struct {
        logic [1:0] win;
        logic       nw;
        logic       to;
        int         iters;
    } result_t;

    result_t exp_q[$];

    // Cycle k after the start edge: phase 0 loads, 1..3 fire r1..r3, 4 is CHECK.
    function automatic logic [5:0] exp_enables(input int k);
        int p;
        p = (k - 1) % 5;
        case (p)
            0:       return {(k == 1), 1'b1, 3'b000, 1'b1};
            1:       return 6'b001001;
            2:       return 6'b000101;
            3:       return 6'b000011;
            default: return 6'b000001;
        endcase
    endfunction

    task automatic run(input string tag, input logic [VW-1:0] x, input logic [1:0] e_win,
                       input logic e_nw, input logic e_to, input int e_it,
                       input int inj_a, input int inj_b);
        result_t e;
        int      k;
        e = '{win: e_win, nw: e_nw, to: e_to, iters: e_it};
        exp_q.push_back(e);
        @(negedge clk);
        x_in  = x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k <= 200) begin
            check_eq({tag, "_enables"}, VW'({w_we, a_we, r1_we, r2_we, r3_we, busy}),
                     VW'(exp_enables(k)));
            start = (k == inj_a) || (k == inj_b);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!done) begin
            check_eq({tag, "_done_seen"}, VW'(done), VW'(1));
            return;
        end
        check_eq({tag, "_winner"},    VW'(winner),     VW'(e.win));
        check_eq({tag, "_no_winner"}, VW'(no_winner),  VW'(e.nw));
        check_eq({tag, "_timeout"},   VW'(timeout),    VW'(e.to));
        check_eq({tag, "_iters"},     VW'(iter_count), VW'(e.iters));
        check_eq({tag, "_latency"},   VW'(k),          VW'(5 * e.iters + 1));
        check_eq({tag, "_done_en"},   VW'({w_we, a_we, r1_we, r2_we, r3_we, busy}), VW'(0));
        $display("run %s: winner=%0d no_winner=%0d timeout=%0d iters=%0d cycles=%0d",
                 tag, winner, no_winner, timeout, iter_count, k);
        @(negedge clk);
        check_eq({tag, "_done_width"}, VW'(done),   VW'(0));
        check_eq({tag, "_win_held"},   VW'(winner), VW'(e.win));
    endtask

    localparam logic [31:0] F0_2 = 32'h3E4CCCCD;
    localparam logic [31:0] F0_4 = 32'h3ECCCCCD;
    localparam logic [31:0] F0_6 = 32'h3F19999A;
    localparam logic [31:0] F0_8 = 32'h3F4CCCCD;
    localparam logic [31:0] F0_5 = 32'h3F000000;
    localparam logic [31:0] F1_0 = 32'h3F800000;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", VW'({w_we, a_we, r1_we, r2_we, r3_we, busy, done,
                                     winner, no_winner, timeout, iter_count}), VW'(0));
        check_eq("rst_act", act_out, '0);
        start = 1'b1;
        @(negedge clk);
        check_eq("rst_start_ignored", VW'(busy), VW'(0));
        start = 1'b0;
        rst_n = 1'b1;

        run("spread", {F0_8, F0_6, F0_4, F0_2}, 2'd3, 1'b0, 1'b0, 5, 2, 10);
        run("single", {32'h0, F1_0, 32'h0, 32'h0}, 2'd2, 1'b0, 1'b0, 1, -1, -1);
        check_eq("single_act", act_out, {32'h0, F1_0, 32'h0, 32'h0});
        run("tie", {F0_5, F0_5, F0_5, F0_5}, 2'd0, 1'b0, 1'b1, MAX_ITER, -1, -1);

        stub_mode = 1'b1;
        stub_val  = '0;
        run("stub_zero", {F0_8, F0_6, F0_4, F0_2}, 2'd0, 1'b1, 1'b0, 1, -1, -1);
        stub_val  = {32'h0, 32'h0, 32'h80000000, 32'h0};
        run("stub_negzero", {F0_8, F0_6, F0_4, F0_2}, 2'd0, 1'b1, 1'b0, 1, -1, -1);

        // Asynchronous reset while the datapaths are in their ReLU stage.
        stub_val = '0;
        @(negedge clk);
        x_in  = {F0_8, F0_6, F0_4, F0_2};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_relu_r3", VW'(r3_we), VW'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_outputs", VW'({w_we, a_we, r1_we, r2_we, r3_we, busy, done,
                                           no_winner, timeout, iter_count}), VW'(0));
        check_eq("async_rst_act", act_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_reset", {F0_8, F0_6, F0_4, F0_2}, 2'd0, 1'b1, 1'b0, 1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_ctrl.md
MAXNET_CTRL -- requirements
Module: maxnet_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DW, 32, activation/result word width (IEEE-754 single).
- NODES, 4, Maxnet node count; one PLU datapath per node.
- MAX_ITER, 15, iteration limit before timeout.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a competition; sampled in IDLE only.
- x_in, in, NODES*DW, initial activations; node i at [i*DW +: DW].
- plu_out, in, NODES*DW, ReLU results from the NODES datapaths.
- act_out, out, NODES*DW, activation vector driven to every datapath's a1..a4.
- w_we, a_we, r1_we, r2_we, r3_we, out, 1 each, stage write enables shared by all datapaths.
- busy, out, 1, high from leaving IDLE until DONE.
- done, out, 1, one-cycle completion pulse.
- winner, out, 2, index of the sole nonzero node; valid when done is pulsed, held until the next start.
- no_winner, out, 1, all results zero at check; held like winner.
- timeout, out, 1, MAX_ITER reached without convergence; held like winner.
- iter_count, out, $clog2(MAX_ITER+1), completed iterations.

Function
REQ-003 FSM states: IDLE, LOAD, MUL, ADD, RELU, CHECK, FEED, DONE.
REQ-004 IDLE with start=1: latch x_in into the act registers, clear winner, no_winner, timeout and iter_count, then go to LOAD.
REQ-005 LOAD: w_we=1 and a_we=1 for one cycle; act_out = latched x_in; next state MUL.
REQ-006 MUL: r1_we=1. ADD: r2_we=1. RELU: r3_we=1. Each state lasts exactly one cycle, in that order.
REQ-007 CHECK: capture plu_out into the act registers; iter_count += 1; count the nonzero nodes (zero means bits[30:0]==0).
REQ-008 CHECK exit priority:
- count==1: winner = that node's index, go to DONE.
- count==0: no_winner=1, go to DONE.
- iter_count (after increment) == MAX_ITER: timeout=1, go to DONE.
- otherwise: go to FEED.
REQ-009 FEED: a_we=1 (w_we=0); act_out = captured results; next state MUL.
REQ-010 Iteration period is 5 cycles (FEED/LOAD, MUL, ADD, RELU, CHECK). start-to-done = 5*N+1 cycles for N iterations.
REQ-011 DONE: done=1 for one cycle, busy=0 in the same cycle, next state IDLE.
REQ-012 Every write enable is 0 in every state except the ones it is listed under.
REQ-013 start outside IDLE is ignored; start held high in IDLE after DONE starts a new run.
REQ-014 Ties (several equal nonzero nodes) are not special-cased; they end by count==0 or by timeout.

Reset
REQ-015 rst_n low: state is IDLE immediately, all enables 0, busy/done/no_winner/timeout 0, winner 0, iter_count 0, act_out 0, regardless of the current state.
REQ-016 Deassertion: the first start is accepted no earlier than the first rising edge with rst_n high.

Structure
REQ-017 Package maxnet_pkg holds:
- DW and NODES;
- the state enum;
- function is_zero (bits[30:0]==0).
REQ-018 One sub-module, maxnet_zero_detect (combinational): takes NODES words and outputs the nonzero count plus the index of the lowest nonzero node.

Verification
REQ-019 Reset mid-RELU: rst_n low -> in the same cycle all enables 0, busy 0, state IDLE; the next start runs a clean 5-cycle iteration.
REQ-020 Four real PLU datapaths, w_ii=1.0, w_ij=-0.2, x={0.2,0.4,0.6,0.8}:
- done, winner=3, no_winner=0, timeout=0;
- iter_count <= MAX_ITER;
- enable sequence a_we,r1_we,r2_we,r3_we repeats every 5 cycles.
REQ-021 x={0,0,1.0,0} (0x3F800000 at node 2): winner=2, iter_count=1, done exactly 6 cycles after the start edge.
REQ-022 x all 0.5 (0x3F000000), same weights: values decay but stay nonzero; timeout=1, iter_count=15, winner=0.
REQ-023 Stub plu_out all 0x00000000 (also 0x80000000 on node 1): no_winner=1 after one iteration, done pulse is 1 cycle wide.
REQ-024 start pulsed during MUL and again during CHECK: no effect; iter_count and the enable sequence are unchanged.
